fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 16-bit, 8-register pipelined MIPS core. It issues PC-sequential reads to a synchronous instruction memory and presents the fetched instruction to decode. It decodes the register fields that the hazard detector consumes. The detector's stall output feeds back into this block to freeze fetch without losing the in-flight read.

---
 rtl/fetch_stage_pkg.sv | 39 +++
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_skid_buf.sv | 36 +++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the 16-bit, 8-register MIPS pipeline.
// Fetch, decode and hazard detection all use these field positions.
package fetch_stage_pkg;

    localparam int PC_W       = 16;
    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [PC_W-1:0]    RESET_PC = '0;
    localparam logic [PC_W-1:0]    PC_INC   = PC_W'(1);
    localparam logic [INSTR_W-1:0] NOP      = '0;

    localparam int OPC_HI = 15, OPC_LO = 12;
    localparam int RS_HI  = 11, RS_LO  = 9;
    localparam int RT_HI  = 8,  RT_LO  = 6;
    localparam int RD_HI  = 5,  RD_LO  = 3;

    typedef logic [PC_W-1:0]       pc_t;
    typedef logic [INSTR_W-1:0]    instr_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_pkt_t;

    function automatic reg_addr_t rs_of(instr_t i);
        return i[RS_HI:RS_LO];
    endfunction

    function automatic reg_addr_t rt_of(instr_t i);
        return i[RT_HI:RT_LO];
    endfunction

    function automatic reg_addr_t rd_of(instr_t i);
        return i[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port and IF/ID outputs of the fetch stage.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic      imem_en;
    pc_t       imem_addr;
    instr_t    imem_rdata;
    logic      id_valid;
    pc_t       id_pc;
    instr_t    id_instr;
    reg_addr_t id_src_1;
    reg_addr_t id_src_2;
    reg_addr_t id_dest;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        output id_valid, id_pc, id_instr, id_src_1, id_src_2, id_dest
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        input  id_valid, id_pc, id_instr, id_src_1, id_src_2, id_dest
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry capture/replay buffer holding the read that was in flight
// when decode stalled. Flush beats load, load beats drain.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       drain_i,
    input  logic       flush_i,
    input  fetch_pkt_t pkt_i,
    output logic       valid_o,
    output fetch_pkt_t pkt_o
);

    logic       valid_q;
    fetch_pkt_t pkt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pkt_q   <= pkt_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register. Stalls park the in-flight read in a
// skid buffer so it is replayed on release without a bubble or a re-fetch.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          stall_i,
    input  logic          branch_taken_i,
    input  pc_t           branch_target_i,
    fetch_stage_if.master bus
);

    pc_t    pc_q, pc_d;
    logic   rsp_valid_q, rsp_valid_d;
    pc_t    rsp_pc_q, rsp_pc_d;
    logic   id_valid_q, id_valid_d;
    pc_t    id_pc_q, id_pc_d;
    instr_t id_instr_q, id_instr_d;

    logic       skid_valid;
    logic       skid_load, skid_drain;
    fetch_pkt_t skid_pkt;
    fetch_pkt_t rsp_pkt;

    assign rsp_pkt = '{pc: rsp_pc_q, instr: bus.imem_rdata};

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (branch_taken_i),
        .pkt_i   (rsp_pkt),
        .valid_o (skid_valid),
        .pkt_o   (skid_pkt)
    );

    always_comb begin
        pc_d        = pc_q;
        rsp_valid_d = 1'b0;
        rsp_pc_d    = rsp_pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        skid_load   = 1'b0;
        skid_drain  = 1'b0;
        if (branch_taken_i) begin
            pc_d       = branch_target_i;
            id_valid_d = 1'b0;
            id_instr_d = NOP;
        end else if (stall_i) begin
            skid_load = rsp_valid_q;
        end else begin
            pc_d        = pc_q + PC_INC;
            rsp_valid_d = 1'b1;
            rsp_pc_d    = pc_q;
            // The skid entry is older than anything on imem_rdata, so it goes first.
            if (skid_valid) begin
                id_valid_d = 1'b1;
                id_pc_d    = skid_pkt.pc;
                id_instr_d = skid_pkt.instr;
                skid_drain = 1'b1;
            end else if (rsp_valid_q) begin
                id_valid_d = 1'b1;
                id_pc_d    = rsp_pc_q;
                id_instr_d = bus.imem_rdata;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= RESET_PC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_instr_q  <= NOP;
        end else begin
            pc_q        <= pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
        end
    end

    assign bus.imem_en   = rst_ni & ~branch_taken_i & ~stall_i;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_instr  = id_instr_q;

    // Gating keeps bubbles from looking like a dependency on some real register.
    assign bus.id_src_1 = id_valid_q ? rs_of(id_instr_q) : '0;
    assign bus.id_src_2 = id_valid_q ? rt_of(id_instr_q) : '0;
    assign bus.id_dest  = id_valid_q ? rd_of(id_instr_q) : '0;

    a_skid_rsp_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(skid_valid && rsp_valid_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard of issued PCs is popped as
// new instructions land in IF/ID; memory returns addr + 0x1000.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic stall  = 1'b0;
    logic branch = 1'b0;
    pc_t  target = '0;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .stall_i         (stall),
        .branch_taken_i  (branch),
        .branch_target_i (target),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    instr_t rdata_q = 16'hDEAD;
    always @(posedge clk) if (bus.imem_en) rdata_q <= bus.imem_addr + 16'h1000;
    assign bus.imem_rdata = rdata_q;

    int   checks = 0;
    int   errors = 0;
    pc_t  sb_q[$];
    pc_t  exp_pc = '0;
    logic stall_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) stall_seen <= stall;

    // A stall edge leaves IF/ID untouched, so only non-stall edges deliver a new entry.
    always @(negedge clk) begin
        pc_t    e;
        instr_t ei;
        if (rst_n && bus.id_valid === 1'b1 && !stall_seen) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e  = sb_q.pop_front();
                ei = e + 16'h1000;
                chk("sb_id_pc", 32'(bus.id_pc), 32'(e));
                chk("sb_id_instr", 32'(bus.id_instr), 32'(ei));
            end
        end
    end

    // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
    task automatic tick(input logic st, input logic br, input pc_t tgt);
        stall  = st;
        branch = br;
        target = tgt;
        #1;
        chk("imem_en", 32'(bus.imem_en), 32'(!st && !br));
        if (!st && !br) begin
            chk("imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
            sb_q.push_back(exp_pc);
            exp_pc = exp_pc + 16'd1;
        end
        @(posedge clk);
        #1;
        if (br) begin
            sb_q.delete();
            exp_pc = tgt;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_en", 32'(bus.imem_en), 32'd0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_pc", 32'(bus.id_pc), 32'd0);
        chk("rst_id_instr", 32'(bus.id_instr), 32'd0);
        chk("rst_src_1", 32'(bus.id_src_1), 32'd0);
        chk("rst_src_2", 32'(bus.id_src_2), 32'd0);
        chk("rst_dest", 32'(bus.id_dest), 32'd0);

        // Free run: first instruction reaches IF/ID two edges after its issue.
        rst_n = 1'b1;
        tick(1'b0, 1'b0, '0);
        chk("lat_valid_early", 32'(bus.id_valid), 32'd0);
        tick(1'b0, 1'b0, '0);
        chk("lat_valid", 32'(bus.id_valid), 32'd1);
        chk("lat_pc", 32'(bus.id_pc), 32'd0);
        chk("lat_instr", 32'(bus.id_instr), 32'h1000);
        run(3);

        // Single-cycle stall: pc 3 held, pc 4 parked in skid.
        tick(1'b1, 1'b0, '0);
        chk("st1_id_pc", 32'(bus.id_pc), 32'd3);
        chk("st1_skid", 32'(dut.skid_valid), 32'd1);
        tick(1'b0, 1'b0, '0);
        chk("st1_replay", 32'(bus.id_pc), 32'd4);
        run(3);
        chk("st1_after", 32'(bus.id_pc), 32'd7);

        // Four-cycle stall.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, '0);
            chk("st4_id_pc", 32'(bus.id_pc), 32'd7);
            chk("st4_skid", 32'(dut.skid_valid), 32'd1);
        end
        run(3);
        chk("st4_after", 32'(bus.id_pc), 32'd10);

        // Redirect while stalled with a full skid.
        tick(1'b1, 1'b0, '0);
        chk("br_pre_skid", 32'(dut.skid_valid), 32'd1);
        tick(1'b1, 1'b1, 16'h0040);
        chk("br_id_valid", 32'(bus.id_valid), 32'd0);
        chk("br_id_instr", 32'(bus.id_instr), 32'd0);
        chk("br_skid", 32'(dut.skid_valid), 32'd0);
        chk("br_rsp", 32'(dut.rsp_valid_q), 32'd0);
        chk("br_src_1", 32'(bus.id_src_1), 32'd0);
        chk("br_dest", 32'(bus.id_dest), 32'd0);
        tick(1'b0, 1'b0, '0);
        chk("br_bubble", 32'(bus.id_valid), 32'd0);
        tick(1'b0, 1'b0, '0);
        chk("br_tgt_valid", 32'(bus.id_valid), 32'd1);
        chk("br_tgt_pc", 32'(bus.id_pc), 32'h0040);

        // Field decode: addr 0x0E28 returns 0x1E28.
        tick(1'b0, 1'b1, 16'h0E28);
        chk("fld_bub_src_2", 32'(bus.id_src_2), 32'd0);
        run(2);
        chk("fld_pc", 32'(bus.id_pc), 32'h0E28);
        chk("fld_src_1", 32'(bus.id_src_1), 32'd7);
        chk("fld_src_2", 32'(bus.id_src_2), 32'd0);
        chk("fld_dest", 32'(bus.id_dest), 32'd5);
        run(1);

        // PC wraps modulo 2^16.
        tick(1'b0, 1'b1, 16'hFFFE);
        run(5);
        chk("wrap_pc", 32'(bus.id_pc), 32'h0001);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_imem_en", 32'(bus.imem_en), 32'd0);
        chk("arst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("arst_pc", 32'(dut.pc_q), 32'(RESET_PC));
        chk("arst_rsp", 32'(dut.rsp_valid_q), 32'd0);
        chk("arst_skid", 32'(dut.skid_valid), 32'd0);
        sb_q.delete();
        exp_pc = RESET_PC;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(2);
        chk("rstrt_pc", 32'(bus.id_pc), 32'd0);
        chk("rstrt_valid", 32'(bus.id_valid), 32'd1);
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
